// File: rtl/focal_mean_sequencer_if.sv
// focal_mean_sequencer_if
//   Groups the control, raster-input and result handshake signals of
//   focal_mean_sequencer.
//   master : the side that drives start/in_valid/in_pixel/out_ready
//            (the raster FIFO and result packer, or a bench).
//   slave  : the sequencer itself.
//   Signals:
//     start     - one-cycle frame request
//     in_valid  - in_pixel holds a cell
//     in_pixel  - 4-bit raster cell, row-major
//     in_ready  - sequencer accepts in_pixel this cycle
//     out_valid - out_mean holds a result
//     out_mean  - 2x2 window mean, zero-extended (max 11)
//     out_ready - downstream accepts out_mean
//     busy      - frame in progress
//     done      - pulse after the last mean of a frame is taken
interface focal_mean_sequencer_if;
    logic       start;
    logic       in_valid;
    logic [3:0] in_pixel;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_mean;
    logic       out_ready;
    logic       busy;
    logic       done;

    modport master (
        output start, in_valid, in_pixel, out_ready,
        input  in_ready, out_valid, out_mean, busy, done
    );

    modport slave (
        input  start, in_valid, in_pixel, out_ready,
        output in_ready, out_valid, out_mean, busy, done
    );
endinterface

// File: rtl/focal_mean_sequencer.sv
// focal_mean_sequencer
//   Walks a COLS x ROWS raster of 4-bit cells through a 2x2 focal mean.
//   A single line buffer supplies the cell above, and left/up-left
//   registers complete the window. Every accepted cell with row>=1 and
//   col>=1 yields one registered mean: (A + B + min(up,7) + min(upleft,7)) >> 2.
//   Ports:
//     clk   - system clock, rising edge
//     rst_n - asynchronous active-low reset
//     bus   - focal_mean_sequencer_if.slave (start, input and output
//             handshakes, busy, done)
module focal_mean_sequencer #(
    parameter int COLS = 8,
    parameter int ROWS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    focal_mean_sequencer_if.slave  bus
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, FLUSH} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [3:0]    line_buf [COLS];
    logic [3:0]    up, left, upleft;
    logic [2:0]    c_sat, d_sat;
    logic [7:0]    sum;
    logic          in_ready;
    logic          acc, emit, out_hs;
    logic          col_last, row_last;
    logic          out_valid_q, done_q;
    logic [7:0]    out_mean_q;

    assign up       = line_buf[col];
    assign col_last = (col == COL_MAX);
    assign row_last = (row == ROW_MAX);
    assign acc      = bus.in_valid && in_ready;
    assign out_hs   = out_valid_q && bus.out_ready;
    // Row 0 and column 0 only prime the window state.
    assign emit     = acc && (row != '0) && (col != '0);

    // The up and up-left operands are only 3 bits wide in the datapath.
    assign c_sat = up[3]     ? 3'd7 : up[2:0];
    assign d_sat = upleft[3] ? 3'd7 : upleft[2:0];
    assign sum   = 8'(bus.in_pixel) + 8'(left) + 8'(c_sat) + 8'(d_sat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = FILL;
            end
            FILL: begin
                in_ready = 1'b1;
                if (acc && col_last) state_nxt = STREAM;
            end
            STREAM: begin
                // A held result blocks new cells so nothing is overwritten.
                in_ready = !out_valid_q || bus.out_ready;
                if (acc && col_last && row_last) state_nxt = FLUSH;
            end
            FLUSH: begin
                if (out_hs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col         <= '0;
            row         <= '0;
            left        <= '0;
            upleft      <= '0;
            out_valid_q <= 1'b0;
            out_mean_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= (state == FLUSH) && out_hs;

            if (state == IDLE && bus.start) begin
                col    <= '0;
                row    <= '0;
                left   <= '0;
                upleft <= '0;
            end else if (acc) begin
                if (col_last) begin
                    col    <= '0;
                    row    <= row_last ? '0 : row + 1'b1;
                    left   <= '0;
                    upleft <= '0;
                end else begin
                    col    <= col + 1'b1;
                    left   <= bus.in_pixel;
                    upleft <= up;
                end
            end

            // A new result takes priority over clearing on a handshake.
            if (emit) begin
                out_valid_q <= 1'b1;
                out_mean_q  <= {2'b00, sum[7:2]};
            end else if (out_hs) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Line buffer contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (acc) line_buf[col] <= bus.in_pixel;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_mean  = out_mean_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_focal_mean_sequencer.sv
module tb_focal_mean_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    focal_mean_sequencer_if a_if ();
    focal_mean_sequencer_if b_if ();

    focal_mean_sequencer #(.COLS(3), .ROWS(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
    focal_mean_sequencer                       dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    int fa [9];
    int fb [64];
    int done_cnt, busy_bad, hold_seen, hold_viol, timed_out;

    function automatic logic [7:0] model(int a, int b, int u, int ul);
        int s;
        s = a + b + (u > 7 ? 7 : u) + (ul > 7 ? 7 : ul);
        return 8'(s / 4);
    endfunction

    // mode 0: out_ready=1; mode 1: out_ready pattern 1,0,0,1;
    // mode 2: start pulses mid-frame and in FLUSH (out_ready held low there)
    task automatic run_a(input int mode, input int abort_after);
        int acc_cnt, cyc, tail, flush_cyc, k;
        bit poked;
        acc_cnt = 0; cyc = 0; tail = 0; flush_cyc = 0; poked = 0;
        done_cnt = 0; busy_bad = 0; hold_seen = 0; hold_viol = 0; timed_out = 0;
        exp_q.delete(); got_q.delete();
        @(negedge clk); a_if.start = 1'b1; a_if.in_valid = 1'b0; a_if.out_ready = 1'b1;
        @(negedge clk); a_if.start = 1'b0;
        forever begin
            a_if.in_valid = 1'b1;
            a_if.in_pixel = (acc_cnt < 9) ? 4'(fa[acc_cnt]) : 4'd0;
            a_if.start    = 1'b0;
            a_if.out_ready = 1'b1;
            if (mode == 1) a_if.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (mode == 2) begin
                if (acc_cnt == 4 && !poked) begin a_if.start = 1'b1; poked = 1; end
                if (acc_cnt == 9 && flush_cyc < 2) begin
                    a_if.out_ready = 1'b0;
                    if (flush_cyc == 0) a_if.start = 1'b1;
                    flush_cyc++;
                end
            end
            #1;
            if (a_if.done) done_cnt++;
            if (done_cnt > 0 && a_if.busy) busy_bad++;
            if (a_if.out_valid && !a_if.out_ready) begin
                hold_seen++;
                if (a_if.in_ready) hold_viol++;
            end
            if (a_if.out_valid && a_if.out_ready) got_q.push_back(a_if.out_mean);
            if (a_if.in_valid && a_if.in_ready && acc_cnt < 9) begin
                k = acc_cnt;
                if (k / 3 >= 1 && k % 3 >= 1)
                    exp_q.push_back(model(fa[k], fa[k-1], fa[k-3], fa[k-4]));
                acc_cnt++;
                if (acc_cnt == abort_after) begin
                    @(posedge clk); #1;
                    a_if.in_valid = 1'b0;
                    return;
                end
            end
            if (done_cnt > 0) tail++;
            if (tail >= 3) break;
            cyc++;
            if (cyc > 300) begin timed_out = 1; break; end
            @(negedge clk);
        end
        a_if.in_valid = 1'b0;
        a_if.start    = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_chk++; if (a_if.in_ready === 1'b0) n_pass++; else $display("FAIL rst_in_ready: got %b want 0", a_if.in_ready);
        n_chk++; if (a_if.out_valid === 1'b0) n_pass++; else $display("FAIL rst_out_valid: got %b want 0", a_if.out_valid);
        n_chk++; if (a_if.out_mean === 8'd0) n_pass++; else $display("FAIL rst_out_mean: got %0d want 0", a_if.out_mean);
        n_chk++; if (a_if.busy === 1'b0) n_pass++; else $display("FAIL rst_busy: got %b want 0", a_if.busy);
        n_chk++; if (a_if.done === 1'b0) n_pass++; else $display("FAIL rst_done: got %b want 0", a_if.done);
        n_chk++; if (b_if.out_valid === 1'b0 && b_if.busy === 1'b0) n_pass++;
        else $display("FAIL rst_b: got out_valid=%b busy=%b want 0 0", b_if.out_valid, b_if.busy);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ramp();
        logic [7:0] e, g;
        for (int i = 0; i < 9; i++) fa[i] = i;
        run_a(0, -1);
        if (timed_out) begin n_chk++; $display("FAIL ramp_timeout: got no done want done"); end
        n_chk++; if (got_q.size() == 4) n_pass++; else $display("FAIL ramp_count: got %0d want 4", got_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_chk++;
            if (g === e) n_pass++; else $display("FAIL ramp_mean: got %0d want %0d", g, e);
        end
        n_chk++; if (done_cnt == 1) n_pass++; else $display("FAIL ramp_done: got %0d pulses want 1", done_cnt);
        n_chk++; if (busy_bad == 0) n_pass++; else $display("FAIL ramp_busy: got %0d busy cycles after done want 0", busy_bad);
    endtask

    task automatic test_saturation();
        logic [7:0] e, g;
        for (int i = 0; i < 9; i++) fa[i] = 15;
        run_a(0, -1);
        if (timed_out) begin n_chk++; $display("FAIL sat_timeout: got no done want done"); end
        n_chk++; if (got_q.size() == 4) n_pass++; else $display("FAIL sat_count: got %0d want 4", got_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_chk++;
            if (g === e) n_pass++; else $display("FAIL sat_mean: got %0d want %0d", g, e);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] e, g;
        for (int i = 0; i < 9; i++) fa[i] = i;
        run_a(1, -1);
        if (timed_out) begin n_chk++; $display("FAIL bp_timeout: got no done want done"); end
        n_chk++; if (got_q.size() == 4) n_pass++; else $display("FAIL bp_count: got %0d want 4", got_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_chk++;
            if (g === e) n_pass++; else $display("FAIL bp_mean: got %0d want %0d", g, e);
        end
        n_chk++; if (hold_seen > 0 && hold_viol == 0) n_pass++;
        else $display("FAIL bp_in_ready: got %0d ready-while-held of %0d held cycles want 0 of >0", hold_viol, hold_seen);
        n_chk++; if (done_cnt == 1) n_pass++; else $display("FAIL bp_done: got %0d pulses want 1", done_cnt);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] e, g;
        for (int i = 0; i < 9; i++) fa[i] = i;
        run_a(0, 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_chk++; if (a_if.in_ready === 1'b0) n_pass++; else $display("FAIL mid_rst_in_ready: got %b want 0", a_if.in_ready);
        n_chk++; if (a_if.out_valid === 1'b0) n_pass++; else $display("FAIL mid_rst_out_valid: got %b want 0", a_if.out_valid);
        n_chk++; if (a_if.out_mean === 8'd0) n_pass++; else $display("FAIL mid_rst_out_mean: got %0d want 0", a_if.out_mean);
        n_chk++; if (a_if.busy === 1'b0) n_pass++; else $display("FAIL mid_rst_busy: got %b want 0", a_if.busy);
        n_chk++; if (a_if.done === 1'b0) n_pass++; else $display("FAIL mid_rst_done: got %b want 0", a_if.done);
        @(negedge clk);
        rst_n = 1'b1;
        run_a(0, -1);
        if (timed_out) begin n_chk++; $display("FAIL mid_timeout: got no done want done"); end
        n_chk++; if (got_q.size() == 4) n_pass++; else $display("FAIL mid_count: got %0d want 4", got_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_chk++;
            if (g === e) n_pass++; else $display("FAIL mid_mean: got %0d want %0d", g, e);
        end
    endtask

    task automatic test_start_ignored();
        logic [7:0] e, g;
        for (int i = 0; i < 9; i++) fa[i] = i;
        run_a(2, -1);
        if (timed_out) begin n_chk++; $display("FAIL poke_timeout: got no done want done"); end
        n_chk++; if (got_q.size() == 4) n_pass++; else $display("FAIL poke_count: got %0d want 4", got_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_chk++;
            if (g === e) n_pass++; else $display("FAIL poke_mean: got %0d want %0d", g, e);
        end
        n_chk++; if (done_cnt == 1 && busy_bad == 0) n_pass++;
        else $display("FAIL poke_restart: got done=%0d busy_after=%0d want 1 0", done_cnt, busy_bad);
    endtask

    task automatic test_random_frame();
        logic [7:0] e, g;
        int acc_cnt, cyc, tail, k;
        for (int i = 0; i < 64; i++) fb[i] = $urandom_range(0, 15);
        fb[9] = 15; fb[10] = 15; fb[17] = 15; fb[18] = 15;
        acc_cnt = 0; cyc = 0; tail = 0; done_cnt = 0; busy_bad = 0; timed_out = 0;
        exp_q.delete(); got_q.delete();
        @(negedge clk); b_if.start = 1'b1; b_if.in_valid = 1'b0; b_if.out_ready = 1'b0;
        @(negedge clk); b_if.start = 1'b0;
        forever begin
            b_if.in_valid  = ($urandom_range(0, 3) != 0);
            b_if.in_pixel  = (acc_cnt < 64) ? 4'(fb[acc_cnt]) : 4'd0;
            b_if.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (b_if.done) done_cnt++;
            if (done_cnt > 0 && b_if.busy) busy_bad++;
            if (b_if.out_valid && b_if.out_ready) got_q.push_back(b_if.out_mean);
            if (b_if.in_valid && b_if.in_ready && acc_cnt < 64) begin
                k = acc_cnt;
                if (k / 8 >= 1 && k % 8 >= 1)
                    exp_q.push_back(model(fb[k], fb[k-1], fb[k-8], fb[k-9]));
                acc_cnt++;
            end
            if (done_cnt > 0) tail++;
            if (tail >= 3) break;
            cyc++;
            if (cyc > 3000) begin timed_out = 1; break; end
            @(negedge clk);
        end
        b_if.in_valid = 1'b0;
        b_if.out_ready = 1'b0;
        if (timed_out) begin n_chk++; $display("FAIL rand_timeout: got no done want done"); end
        n_chk++; if (got_q.size() == 49) n_pass++; else $display("FAIL rand_count: got %0d want 49", got_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_chk++;
            if (g === e) n_pass++; else $display("FAIL rand_mean: got %0d want %0d", g, e);
        end
        n_chk++; if (done_cnt == 1 && busy_bad == 0) n_pass++;
        else $display("FAIL rand_done: got done=%0d busy_after=%0d want 1 0", done_cnt, busy_bad);
    endtask

    initial begin
        a_if.start = 1'b0; a_if.in_valid = 1'b0; a_if.in_pixel = 4'd0; a_if.out_ready = 1'b0;
        b_if.start = 1'b0; b_if.in_valid = 1'b0; b_if.in_pixel = 4'd0; b_if.out_ready = 1'b0;
        test_reset();
        test_ramp();
        test_saturation();
        test_backpressure();
        test_reset_mid_frame();
        test_start_ignored();
        test_random_frame();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
